inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Fetch stage directly downstream of the program-counter register. Takes the current pc and a strobe, reads the instruction from a variable-latency instruction memory over a req/ack handshake, then presents the instruction word and its pre-split fields to decode.
- Reports misalignment and memory timeouts. Detects the HALT opcode and freezes fetch.

Parameters:
- MEM_LAT_MAX, 15, maximum number of req-high cycles without mem_ack before a timeout fault (1..255).
- HALT_OPCODE, 6'h3F, opcode value that halts fetch.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous active-low reset.
- pc  input  32  byte address to fetch.
- pc_valid  input  1  single-cycle strobe: pc is new and must be fetched.
- mem_addr  output  32  address to instruction memory, word aligned.
- mem_req  output  1  read request, held until ack.
- mem_ack  input  1  memory has driven mem_rdata this cycle.
- mem_rdata  input  32  instruction word.
- ins  output  32  fetched instruction (0 on fault).
- opcode  output  6  ins[31:26].
- immd16  output  16  ins[15:0].
- immd26  output  26  ins[25:0].
- ins_valid  output  1  one-cycle pulse: ins/fields are new.
- stall  output  1  fetch busy; upstream must hold pc and must not strobe.
- fault  output  1  misaligned pc or memory timeout on the last fetch.
- halted  output  1  sticky: HALT opcode fetched.

Behaviour:
- Reset (RST low, asynchronous, any state):
  - state=IDLE.
  - mem_req=0, mem_addr=0, ins=0, ins_valid=0, stall=0, fault=0, halted=0, timeout counter=0.
  - A request in flight is abandoned. A mem_ack after reset release is ignored in IDLE.
- Field outputs opcode/immd16/immd26 are combinational slices of the registered ins.
- FSM states: IDLE, WAIT, HALT.
- IDLE:
  - pc_valid=1, halted=0, pc[1:0]==0: latch mem_addr=pc; mem_req=1, stall=1, fault=0, counter=0; go WAIT.
  - pc_valid=1, pc[1:0]!=0: no request; ins=0, fault=1, ins_valid=1 for one cycle; stay IDLE.
  - pc_valid=0: hold all registered outputs; ins_valid=0.
- WAIT:
  - Edge with mem_ack=1: ins=mem_rdata, ins_valid=1, mem_req=0, stall=0.
  - If mem_rdata[31:26]==HALT_OPCODE: halted=1, go HALT. Otherwise go IDLE.
  - Edge with mem_ack=0: counter increments. When the counter reaches MEM_LAT_MAX: mem_req=0, ins=0, fault=1, ins_valid=1, stall=0; go IDLE.
  - Ack and timeout on the same edge: ack wins, no fault.
  - pc_valid in WAIT is ignored (protocol violation; stall is high).
  - mem_addr is stable while mem_req=1.
- HALT:
  - stall=1 and mem_req=0 permanently; pc_valid ignored.
  - ins retains the HALT word; ins_valid=0.
  - Exit only via reset.
- Latency (zero-wait memory acking in its first req cycle):
  - pc_valid sampled at edge N; mem_req high after N.
  - mem_ack sampled at edge N+1; ins_valid high in the cycle after N+1.
  - Each memory wait cycle adds one cycle.
- fault is held until the next accepted pc_valid.
- ins holds its value between fetches.

Optional Feature:
- Macro: FETCH_CACHE_EN.
- Defined: one-entry last-instruction buffer holding tag (32-bit address), data, and a valid bit.
  - Cleared on reset.
  - Written on every successful (non-fault) ack.
  - In IDLE, pc_valid with aligned pc equal to a valid tag: no memory request; ins=buffered data, ins_valid=1 at the same edge (1-cycle latency); HALT check still applies.
  - Faults never write the buffer.
- Not defined: every fetch goes to memory; no tag storage is synthesized.

Test Plan:
- Reset, pc=0x00000010, pc_valid pulse, memory acks after 1 cycle with 0x8C220004 -> mem_addr=0x10; ins=0x8C220004, opcode=0x23, immd16=0x0004, single ins_valid pulse 2 cycles after strobe.
- Memory waits 5 cycles, MEM_LAT_MAX=15 -> stall high for 6 cycles, mem_req held with mem_addr constant, then ins_valid, no fault.
- No ack for 15 cycles -> mem_req drops, fault=1, ins=0, ins_valid pulse. A late ack 3 cycles later is ignored. Next strobe at pc=0x14 clears fault.
- pc=0x00000006 strobed -> no mem_req, fault=1, ins=0, ins_valid pulse.
- Memory returns 0xFC000000 -> halted=1, stall stays 1, further pc_valid strobes produce no mem_req. Asserting RST clears all outputs.
- FETCH_CACHE_EN: fetch 0x20 (latency 2), strobe 0x20 again -> no mem_req, ins_valid next cycle. Strobe 0x24 -> memory access. RST low while mem_req high -> mem_req=0 immediately.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetches one instruction per pc strobe over a req/ack memory port.
// Define FETCH_CACHE_EN to add a one-entry last-instruction buffer.
module inst_fetch_unit #(
    parameter int         MEM_LAT_MAX = 15,
    parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ins,
    output logic [5:0]  opcode,
    output logic [15:0] immd16,
    output logic [25:0] immd26,
    output logic        ins_valid,
    output logic        stall,
    output logic        fault,
    output logic        halted
);
    typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;
    localparam logic [7:0] LAT = 8'(MEM_LAT_MAX);
    state_t      state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic        hit;
    logic [31:0] hit_data;
    assign cnt_nx = cnt + 8'd1;
    assign opcode = ins[31:26];
    assign immd16 = ins[15:0];
    assign immd26 = ins[25:0];
`ifdef FETCH_CACHE_EN
    logic [31:0] tag;
    logic [31:0] cdata;
    logic        cvalid;
    assign hit      = cvalid && tag == pc;
    assign hit_data = cdata;
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            tag    <= '0;
            cdata  <= '0;
            cvalid <= 1'b0;
        end else if (state == WAIT && mem_ack) begin
            tag    <= mem_addr;
            cdata  <= mem_rdata;
            cvalid <= 1'b1;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_req   <= 1'b0;
            ins       <= '0;
            ins_valid <= 1'b0;
            stall     <= 1'b0;
            fault     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            ins_valid <= 1'b0;
            case (state)
                IDLE: if (pc_valid && !halted) begin
                    if (pc[1:0] != 2'b00) begin
                        ins       <= '0;
                        fault     <= 1'b1;
                        ins_valid <= 1'b1;
                    end else if (hit) begin
                        ins       <= hit_data;
                        ins_valid <= 1'b1;
                        fault     <= 1'b0;
                        if (hit_data[31:26] == HALT_OPCODE) begin
                            halted <= 1'b1;
                            stall  <= 1'b1;
                            state  <= HALT;
                        end
                    end else begin
                        mem_addr <= pc;
                        mem_req  <= 1'b1;
                        stall    <= 1'b1;
                        fault    <= 1'b0;
                        cnt      <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        ins       <= mem_rdata;
                        ins_valid <= 1'b1;
                        mem_req   <= 1'b0;
                        halted    <= mem_rdata[31:26] == HALT_OPCODE;
                        stall     <= mem_rdata[31:26] == HALT_OPCODE;
                        state     <= mem_rdata[31:26] == HALT_OPCODE ? HALT : IDLE;
                    end else begin
                        cnt <= cnt_nx;
                        if (cnt_nx == LAT) begin
                            mem_req   <= 1'b0;
                            ins       <= '0;
                            fault     <= 1'b1;
                            ins_valid <= 1'b1;
                            stall     <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                HALT: begin
                    stall   <= 1'b1;
                    mem_req <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: table vectors, directed corner sequences and randomized fetches
// checked against a transaction-level model of the fetch unit.
module tb_inst_fetch_unit;
    localparam int LAT = 15;
`ifdef FETCH_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr, ins;
    logic        mem_req, ins_valid, stall, fault, halted;
    logic [5:0]  opcode;
    logic [15:0] immd16;
    logic [25:0] immd26;
    int checks = 0;
    int errors = 0;

    inst_fetch_unit dut (
        .clk(clk), .RST(RST), .pc(pc), .pc_valid(pc_valid),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins(ins), .opcode(opcode), .immd16(immd16), .immd26(immd26),
        .ins_valid(ins_valid), .stall(stall), .fault(fault), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // reference model: one entry per completed transaction
    logic [31:0] m_ins, m_tag, m_data;
    logic        m_fault, m_halt, m_cv;

    task automatic model_reset();
        m_ins = '0; m_fault = 1'b0; m_halt = 1'b0; m_cv = 1'b0; m_tag = '0; m_data = '0;
    endtask

    task automatic model(input logic [31:0] p, input int dly, input logic [31:0] d,
                         output int er, output logic ev);
        er = 0;
        ev = 1'b1;
        if (m_halt) ev = 1'b0;
        else if (p[1:0] != 2'b00) begin
            m_ins = '0; m_fault = 1'b1;
        end else if (CACHE && m_cv && m_tag == p) begin
            m_ins = m_data; m_fault = 1'b0; m_halt = m_data[31:26] == 6'h3F;
        end else if (dly < LAT) begin
            er = dly + 1; m_ins = d; m_fault = 1'b0; m_halt = d[31:26] == 6'h3F;
            m_cv = 1'b1; m_tag = p; m_data = d;
        end else begin
            er = LAT; m_ins = '0; m_fault = 1'b1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] p, input int dly, input logic [31:0] d,
                            input int er, input logic [31:0] ei, input logic ef,
                            input logic eh, input logic ev);
        int k;
        pc = p;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        k = 0;
        while (mem_req && k < 40) begin
            chk("mem_addr", mem_addr, p);
            chk("stall_busy", 32'(stall), 32'd1);
            mem_ack = k == dly;
            mem_rdata = mem_ack ? d : $urandom;
            @(negedge clk);
            k++;
        end
        mem_ack = 1'b0;
        chk("req_cycles", 32'(k), 32'(er));
        chk("ins_valid", 32'(ins_valid), 32'(ev));
        chk("ins", ins, ei);
        chk("opcode", 32'(opcode), 32'(ei[31:26]));
        chk("immd16", 32'(immd16), 32'(ei[15:0]));
        chk("immd26", 32'(immd26), 32'(ei[25:0]));
        chk("fault", 32'(fault), 32'(ef));
        chk("halted", 32'(halted), 32'(eh));
        chk("stall", 32'(stall), 32'(eh));
        @(negedge clk);
        chk("ins_valid_pulse", 32'(ins_valid), 32'd0);
        chk("mem_req_idle", 32'(mem_req), 32'd0);
    endtask

    task automatic run(input logic [31:0] p, input int dly, input logic [31:0] d);
        int er;
        logic ev;
        model(p, dly, d, er, ev);
        do_fetch(p, dly, d, er, m_ins, m_fault, m_halt, ev);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({nm, "_mem_addr"}, mem_addr, 32'd0);
        chk({nm, "_ins"}, ins, 32'd0);
        chk({nm, "_ins_valid"}, 32'(ins_valid), 32'd0);
        chk({nm, "_stall"}, 32'(stall), 32'd0);
        chk({nm, "_fault"}, 32'(fault), 32'd0);
        chk({nm, "_halted"}, 32'(halted), 32'd0);
    endtask

    typedef struct {
        logic [31:0] p;
        int          dly;
        logic [31:0] d;
        int          er;
        logic [31:0] ei;
        logic        ef;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int er;
        logic ev;
        logic [31:0] d;
        int r, dly;
        tbl[0] = '{32'h10, 0,  32'h8C220004, 1,  32'h8C220004, 1'b0};
        tbl[1] = '{32'h14, 5,  32'h12345678, 6,  32'h12345678, 1'b0};
        tbl[2] = '{32'h06, 0,  32'h11111111, 0,  32'h0,        1'b1};
        tbl[3] = '{32'h18, 14, 32'hA5A50001, 15, 32'hA5A50001, 1'b0};
        tbl[4] = '{32'h1C, 15, 32'h22222222, 15, 32'h0,        1'b1};
        tbl[5] = '{32'h20, 1,  32'h00ABCDEF, 2,  32'h00ABCDEF, 1'b0};
        tbl[6] = '{32'h23, 0,  32'h33333333, 0,  32'h0,        1'b1};
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        RST = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        for (int i = 0; i < 7; i++) begin
            model(tbl[i].p, tbl[i].dly, tbl[i].d, er, ev);
            do_fetch(tbl[i].p, tbl[i].dly, tbl[i].d, tbl[i].er, tbl[i].ei, tbl[i].ef, 1'b0, 1'b1);
        end

        // timeout, then a late ack must be ignored and fault held
        run(32'h30, 99, 32'h44444444);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_valid", 32'(ins_valid), 32'd0);
        chk("late_ack_ins", ins, 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_fault", 32'(fault), 32'd1);
        run(32'h14, 0, 32'h55555555);

        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            dly = r < 7 ? r : (r == 7 ? 14 : (r == 8 ? 15 : 30));
            d = $urandom;
            if (d[31:26] == 6'h3F) d[26] = 1'b0;
            run(32'h100 + 32'($urandom_range(0, 7) << 2) +
                ($urandom_range(0, 5) == 0 ? 32'($urandom_range(1, 3)) : 32'd0), dly, d);
        end

        // reset while a request is outstanding
        pc = 32'h50;
        pc_valid = 1'b1;
        @(negedge clk);
        pc_valid = 1'b0;
        chk("inflight_req", 32'(mem_req), 32'd1);
        #2 RST = 1'b0;
        #1 chk_zero("async_reset");
        model_reset();
        @(negedge clk);
        RST = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h66666666;
        @(negedge clk);
        mem_ack = 1'b0;
        chk_zero("ack_in_idle");

`ifdef FETCH_CACHE_EN
        run(32'h20, 1, 32'h77777777);
        chk("cache_hit_model", 32'(m_cv && m_tag == 32'h20), 32'd1);
        do_fetch(32'h20, 0, 32'h88888888, 0, 32'h77777777, 1'b0, 1'b0, 1'b1);
        model(32'h20, 0, 32'h88888888, er, ev);
        run(32'h24, 0, 32'h99999999);
`endif

        // HALT opcode freezes fetch until reset
        run(32'h60, 2, 32'hFC000000);
        run(32'h64, 0, 32'h12121212);
        run(32'h68, 0, 32'h13131313);
        @(negedge clk);
        RST = 1'b0;
        #1 chk_zero("halt_reset");
        @(negedge clk);
        RST = 1'b1;
        model_reset();
        run(32'h70, 0, 32'h01020304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
